contador_modn: RTL and testbench
================================

CONTADOR_MODN -- requirements
Module: contador_modn

Interface
REQ-001 The module SHALL take parameter MODULUS, default 10, as the count modulus; the legal range is 2..256.
REQ-002 The module SHALL take parameter WIDTH, default 4, as the counter width; the constraint 2**WIDTH >= MODULUS SHALL be checked at elaboration, and a violation SHALL be fatal.
REQ-003 The module SHALL take parameter ONESHOT, default 0: 0 = wrap-around mode, 1 = stop at terminal count.
REQ-004 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 clrn  input  1  reset, asynchronous, active-low.
REQ-006 loadn  input  1  synchronous load, active-low.
REQ-007 enable  input  1  count enable, active-high; also the cascade input from a lower digit's tc.
REQ-008 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-009 data  input  WIDTH  load value.
REQ-010 count  output  WIDTH  current count value, registered.
REQ-011 tc  output  1  terminal-count / cascade output, combinational.
REQ-012 zero  output  1  high when count == 0, combinational.
REQ-013 done  output  1  one-shot completion flag, registered; constant 0 when ONESHOT=0.

Function
REQ-014 Each clock edge SHALL apply exactly one action, in this priority: load (loadn=0) > halted hold (done=1) > count (enable=1) > hold.
REQ-015 On a load, count SHALL take data if data <= MODULUS-1, otherwise MODULUS-1 (clamp); the load SHALL also clear done.
REQ-016 Up-count SHALL go MODULUS-1 -> 0 on wrap; otherwise count+1.
REQ-017 Down-count SHALL go 0 -> MODULUS-1 on wrap; otherwise count-1.
REQ-018 The terminal value SHALL be MODULUS-1 when up=1 and 0 when up=0.
REQ-019 tc SHALL equal enable & (count == terminal) & ~done & loadn.
REQ-020 tc SHALL track a change of up within the same cycle, with no registered delay.
REQ-021 In ONESHOT=1, a count edge with count == terminal SHALL set done=1 and leave count unchanged (no wrap).
REQ-022 While done=1, count SHALL hold, tc SHALL be 0, and enable and up SHALL be ignored; only a load or a reset clears done.
REQ-023 In ONESHOT=0, done SHALL remain 0 and count SHALL wrap per REQ-016 and REQ-017 indefinitely.
REQ-024 When loadn=0 and enable=1 in the same cycle, the load SHALL win and no count step SHALL occur that cycle.
REQ-025 A change of up between edges SHALL take effect on the next count edge; no extra state is held for direction.
REQ-026 The count register SHALL never hold a value >= MODULUS under any input sequence.
REQ-027 Count latency SHALL be one edge: the value after edge N reflects the inputs sampled at edge N.

Reset
REQ-028 While clrn=0, count SHALL be 0 and done SHALL be 0, forced asynchronously without waiting for a clock edge.
REQ-029 While clrn=0, zero SHALL be 1 and tc SHALL be enable & ~up & loadn (consistent with count=0), and all clock edges SHALL be ignored.
REQ-030 A reset asserted mid-count SHALL discard the count in progress.
REQ-031 After clrn deasserts, the first edge SHALL behave per REQ-014 from count=0.

Verification
REQ-032 The bench SHALL cover, with MODULUS=10 and up=0: load 8, then enable=1 for 10 edges -> count 8,7,...,1,0,9; tc=1 only in the cycle where count=0 and enable=1; zero=1 only at count=0.
REQ-033 The bench SHALL cover, with MODULUS=10 and up=1: load 7, enable -> count 7,8,9,0; tc=1 at count=9; up=0 at count=0 gives tc=1 in the same cycle.
REQ-034 The bench SHALL cover, with MODULUS=10: load data=12 -> count=9; load data=15 with WIDTH=4 -> count=9.
REQ-035 The bench SHALL cover, with ONESHOT=1, MODULUS=6, up=0: load 2, enable -> count 2,1,0; the next edge sets done=1 and count stays 0; further enables give tc=0; load 5 -> done=0, count=5.
REQ-036 The bench SHALL cover loadn=0 with enable=1 at count=3 and data=4 -> count=4 (no decrement).
REQ-037 The bench SHALL cover clrn pulsed low between edges at count=5 -> count=0 and zero=1 immediately, done=0; counting resumes from 0 on the first edge after release.

Source files
------------

// File: rtl/contador_modn.sv
// rtl/contador_modn.sv - modulo-N up/down counter with clamped load, cascade tc and optional one-shot stop
module contador_modn #(
  parameter int MODULUS = 10,
  parameter int WIDTH   = 4,
  parameter int ONESHOT = 0
) (
  input  logic             clock,
  input  logic             clrn,
  input  logic             loadn,
  input  logic             enable,
  input  logic             up,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             zero,
  output logic             done
);

  generate
    if (MODULUS < 2 || MODULUS > 256) begin : g_bad_modulus
      $fatal(1, "contador_modn: MODULUS must lie in 2..256");
    end
    if (WIDTH < 1 || WIDTH > 30) begin : g_bad_width
      $fatal(1, "contador_modn: WIDTH out of supported range");
    end else if ((2 ** WIDTH) < MODULUS) begin : g_narrow_width
      $fatal(1, "contador_modn: 2**WIDTH must be >= MODULUS");
    end
  endgenerate

  localparam logic [WIDTH-1:0] TOP   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO  = '0;
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam bit               STOPS = (ONESHOT != 0);

  logic [WIDTH-1:0] r_count;
  logic             r_done;

  logic [WIDTH-1:0] w_next_count;
  logic             w_next_done;
  logic [WIDTH-1:0] w_terminal;
  logic             w_at_terminal;
  logic [WIDTH-1:0] w_load_value;
  logic [WIDTH-1:0] w_step_value;

  // Terminal follows 'up' combinationally so a direction flip shows on tc at once.
  assign w_terminal    = up ? TOP : ZERO;
  assign w_at_terminal = (r_count == w_terminal);

  // Out-of-range loads clamp so the register can never leave 0..MODULUS-1.
  assign w_load_value  = (data > TOP) ? TOP : data;

  always_comb begin
    w_step_value = r_count;
    if (up) begin
      if (r_count == TOP) w_step_value = ZERO;
      else                w_step_value = r_count + ONE;
    end else begin
      if (r_count == ZERO) w_step_value = TOP;
      else                 w_step_value = r_count - ONE;
    end
  end

  always_comb begin
    w_next_count = r_count;
    w_next_done  = r_done;
    if (!loadn) begin
      w_next_count = w_load_value;
      w_next_done  = 1'b0;
    end else if (r_done) begin
      w_next_count = r_count;
    end else if (enable) begin
      if (STOPS && w_at_terminal) begin
        w_next_done = 1'b1;
      end else begin
        w_next_count = w_step_value;
      end
    end
  end

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      r_count <= ZERO;
      r_done  <= 1'b0;
    end else begin
      r_count <= w_next_count;
      r_done  <= STOPS ? w_next_done : 1'b0;
    end
  end

  assign count = r_count;
  assign done  = r_done;
  assign zero  = (r_count == ZERO);
  assign tc    = enable & w_at_terminal & ~r_done & loadn;

endmodule

// File: tb/tb_contador_modn.sv
// tb/tb_contador_modn.sv - directed self-checking bench for contador_modn (wrap and one-shot instances)
module tb_contador_modn;

  logic       clock = 1'b0;
  logic       clrn  = 1'b0;

  logic       a_loadn = 1'b1, a_enable = 1'b0, a_up = 1'b0;
  logic [3:0] a_data = 4'd0;
  logic [3:0] a_count;
  logic       a_tc, a_zero, a_done;

  logic       b_loadn = 1'b1, b_enable = 1'b0, b_up = 1'b0;
  logic [2:0] b_data = 3'd0;
  logic [2:0] b_count;
  logic       b_tc, b_zero, b_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  contador_modn #(.MODULUS(10), .WIDTH(4), .ONESHOT(0)) u_wrap (
    .clock(clock), .clrn(clrn), .loadn(a_loadn), .enable(a_enable), .up(a_up),
    .data(a_data), .count(a_count), .tc(a_tc), .zero(a_zero), .done(a_done)
  );

  contador_modn #(.MODULUS(6), .WIDTH(3), .ONESHOT(1)) u_shot (
    .clock(clock), .clrn(clrn), .loadn(b_loadn), .enable(b_enable), .up(b_up),
    .data(b_data), .count(b_count), .tc(b_tc), .zero(b_zero), .done(b_done)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_a(input logic [3:0] v);
    a_loadn = 1'b0; a_data = v; a_enable = 1'b0;
    tick();
    a_loadn = 1'b1;
    #1;
  endtask

  task automatic load_b(input logic [2:0] v);
    b_loadn = 1'b0; b_data = v; b_enable = 1'b0;
    tick();
    b_loadn = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    clrn = 1'b0; a_enable = 1'b0; a_up = 1'b1;
    #2;
    n_checks++; if (a_count !== 4'd0) begin $display("FAIL reset_count got %0d want 0", a_count); n_fail++; end
    n_checks++; if (a_zero !== 1'b1) begin $display("FAIL reset_zero got %b want 1", a_zero); n_fail++; end
    n_checks++; if (a_done !== 1'b0) begin $display("FAIL reset_done got %b want 0", a_done); n_fail++; end
    n_checks++; if (b_done !== 1'b0) begin $display("FAIL reset_b_done got %b want 0", b_done); n_fail++; end
    n_checks++; if (a_tc !== 1'b0) begin $display("FAIL reset_tc_idle got %b want 0", a_tc); n_fail++; end
    a_enable = 1'b1; a_up = 1'b0;
    #1;
    n_checks++; if (a_tc !== 1'b1) begin $display("FAIL reset_tc_down got %b want 1", a_tc); n_fail++; end
    a_loadn = 1'b0; a_data = 4'd5;
    tick();
    n_checks++; if (a_count !== 4'd0) begin $display("FAIL reset_ignores_edge got %0d want 0", a_count); n_fail++; end
    n_checks++; if (a_tc !== 1'b0) begin $display("FAIL reset_tc_loadn got %b want 0", a_tc); n_fail++; end
    a_loadn = 1'b1; a_enable = 1'b0;
    #1;
    clrn = 1'b1;
    tick();
  endtask

  task automatic test_down_wrap();
    int pre [10] = '{8, 7, 6, 5, 4, 3, 2, 1, 0, 9};
    a_up = 1'b0;
    load_a(4'd8);
    a_enable = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (a_count !== 4'(pre[i])) begin $display("FAIL down_count[%0d] got %0d want %0d", i, a_count, pre[i]); n_fail++; end
      n_checks++; if (a_tc !== (pre[i] == 0)) begin $display("FAIL down_tc[%0d] got %b want %b", i, a_tc, pre[i] == 0); n_fail++; end
      n_checks++; if (a_zero !== (pre[i] == 0)) begin $display("FAIL down_zero[%0d] got %b want %b", i, a_zero, pre[i] == 0); n_fail++; end
      tick();
    end
    n_checks++; if (a_count !== 4'd8) begin $display("FAIL down_final got %0d want 8", a_count); n_fail++; end
    n_checks++; if (a_done !== 1'b0) begin $display("FAIL wrap_done got %b want 0", a_done); n_fail++; end
    a_enable = 1'b0;
  endtask

  task automatic test_up_wrap();
    int pre [3] = '{7, 8, 9};
    a_up = 1'b1;
    load_a(4'd7);
    a_enable = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (a_count !== 4'(pre[i])) begin $display("FAIL up_count[%0d] got %0d want %0d", i, a_count, pre[i]); n_fail++; end
      n_checks++; if (a_tc !== (pre[i] == 9)) begin $display("FAIL up_tc[%0d] got %b want %b", i, a_tc, pre[i] == 9); n_fail++; end
      tick();
    end
    n_checks++; if (a_count !== 4'd0) begin $display("FAIL up_wrap got %0d want 0", a_count); n_fail++; end
    n_checks++; if (a_tc !== 1'b0) begin $display("FAIL up_tc_at0 got %b want 0", a_tc); n_fail++; end
    a_up = 1'b0;
    #1;
    n_checks++; if (a_tc !== 1'b1) begin $display("FAIL dir_flip_tc got %b want 1", a_tc); n_fail++; end
    tick();
    n_checks++; if (a_count !== 4'd9) begin $display("FAIL dir_flip_step got %0d want 9", a_count); n_fail++; end
    a_enable = 1'b0;
  endtask

  task automatic test_load_clamp();
    load_a(4'd12);
    n_checks++; if (a_count !== 4'd9) begin $display("FAIL clamp12 got %0d want 9", a_count); n_fail++; end
    load_a(4'd0);
    load_a(4'd15);
    n_checks++; if (a_count !== 4'd9) begin $display("FAIL clamp15 got %0d want 9", a_count); n_fail++; end
    load_a(4'd0);
    n_checks++; if (a_zero !== 1'b1) begin $display("FAIL load0_zero got %b want 1", a_zero); n_fail++; end
  endtask

  task automatic test_load_priority();
    a_up = 1'b0;
    load_a(4'd3);
    a_loadn = 1'b0; a_data = 4'd4; a_enable = 1'b1;
    #1;
    n_checks++; if (a_tc !== 1'b0) begin $display("FAIL prio_tc got %b want 0", a_tc); n_fail++; end
    tick();
    n_checks++; if (a_count !== 4'd4) begin $display("FAIL prio_load got %0d want 4", a_count); n_fail++; end
    a_loadn = 1'b1; a_enable = 1'b0;
  endtask

  task automatic test_oneshot();
    b_up = 1'b0;
    load_b(3'd2);
    b_enable = 1'b1;
    #1;
    tick();
    n_checks++; if (b_count !== 3'd1) begin $display("FAIL shot_c1 got %0d want 1", b_count); n_fail++; end
    tick();
    n_checks++; if (b_count !== 3'd0) begin $display("FAIL shot_c0 got %0d want 0", b_count); n_fail++; end
    n_checks++; if (b_tc !== 1'b1) begin $display("FAIL shot_tc_at0 got %b want 1", b_tc); n_fail++; end
    tick();
    n_checks++; if (b_done !== 1'b1) begin $display("FAIL shot_done got %b want 1", b_done); n_fail++; end
    n_checks++; if (b_count !== 3'd0) begin $display("FAIL shot_hold got %0d want 0", b_count); n_fail++; end
    n_checks++; if (b_tc !== 1'b0) begin $display("FAIL shot_tc_done got %b want 0", b_tc); n_fail++; end
    b_up = 1'b1;
    tick();
    tick();
    n_checks++; if (b_count !== 3'd0) begin $display("FAIL shot_ignore_up got %0d want 0", b_count); n_fail++; end
    n_checks++; if (b_tc !== 1'b0) begin $display("FAIL shot_tc_up got %b want 0", b_tc); n_fail++; end
    b_up = 1'b0;
    load_b(3'd5);
    n_checks++; if (b_done !== 1'b0) begin $display("FAIL shot_reload_done got %b want 0", b_done); n_fail++; end
    n_checks++; if (b_count !== 3'd5) begin $display("FAIL shot_reload_count got %0d want 5", b_count); n_fail++; end
    b_up = 1'b1; b_enable = 1'b1;
    tick();
    n_checks++; if (b_done !== 1'b1 || b_count !== 3'd5) begin $display("FAIL shot_up_stop got done=%b count=%0d want done=1 count=5", b_done, b_count); n_fail++; end
    b_enable = 1'b0;
  endtask

  task automatic test_async_reset();
    load_a(4'd5);
    n_checks++; if (a_count !== 4'd5) begin $display("FAIL pre_reset got %0d want 5", a_count); n_fail++; end
    #1;
    clrn = 1'b0;
    #1;
    n_checks++; if (a_count !== 4'd0) begin $display("FAIL async_count got %0d want 0", a_count); n_fail++; end
    n_checks++; if (a_zero !== 1'b1) begin $display("FAIL async_zero got %b want 1", a_zero); n_fail++; end
    n_checks++; if (b_done !== 1'b0) begin $display("FAIL async_b_done got %b want 0", b_done); n_fail++; end
    n_checks++; if (b_count !== 3'd0) begin $display("FAIL async_b_count got %0d want 0", b_count); n_fail++; end
    clrn = 1'b1;
    a_up = 1'b1; a_enable = 1'b1;
    tick();
    n_checks++; if (a_count !== 4'd1) begin $display("FAIL resume got %0d want 1", a_count); n_fail++; end
    a_enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_down_wrap();
    test_up_wrap();
    test_load_clamp();
    test_load_priority();
    test_oneshot();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
